// File: rtl/req_rsp_elastic_buf_if.sv
// Ready/valid bundle for the elastic buffer: upstream in_* and downstream out_* streams.
// master is the producer/consumer side; slave is the buffer itself.
interface req_rsp_elastic_buf_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/req_rsp_elastic_buf.sv
// Elastic FIFO stage between the req_* and rsp_* streams. All outputs are registered,
// so there is no combinational path from in_* to out_*; minimum latency is one cycle.
module req_rsp_elastic_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    req_rsp_elastic_buf_if.slave   bus,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       in_count,
    output logic [CNT_W-1:0]       out_count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_nxt_s;
    logic [PTR_W-1:0]  rd_ptr_nxt_s;
    logic [PTR_W-1:0]  level_nxt_s;
    logic [PTR_W-1:0]  level_r;
    logic              push_s;
    logic              pop_s;
    logic              full_nxt_s;
    logic              empty_nxt_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] head_nxt_s;
    logic [DATA_W-1:0] out_data_r;
    logic [CNT_W-1:0]  in_count_r;
    logic [CNT_W-1:0]  out_count_r;

    // Next-state pointers, flags and head word derived from the handshakes.
    always_comb begin
        push_s = bus.in_valid & in_ready_r;
        pop_s  = out_valid_r & bus.out_ready;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        level_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
        empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
        full_nxt_s  = (wr_ptr_nxt_s[IDX_W-1:0] == rd_ptr_nxt_s[IDX_W-1:0]) &&
                      (wr_ptr_nxt_s[IDX_W] != rd_ptr_nxt_s[IDX_W]);
        // A word written into the slot that becomes the head must be forwarded.
        if (push_s && (wr_ptr_r[IDX_W-1:0] == rd_ptr_nxt_s[IDX_W-1:0])) begin
            head_nxt_s = bus.in_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s[IDX_W-1:0]];
        end
    end

    // Storage write; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clock) begin
        if (push_s && !reset) begin
            mem_r[wr_ptr_r[IDX_W-1:0]] <= bus.in_data;
        end
    end

    // Pointers, registered status flags, head data and transfer counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            level_r     <= {PTR_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            in_count_r  <= {CNT_W{1'b0}};
            out_count_r <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            level_r     <= level_nxt_s;
            in_ready_r  <= !full_nxt_s;
            out_valid_r <= !empty_nxt_s;
            out_data_r  <= head_nxt_s;
            if (push_s) begin
                in_count_r <= in_count_r + CNT_W'(1);
            end
            if (pop_s) begin
                out_count_r <= out_count_r + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign level         = level_r;
    assign in_count      = in_count_r;
    assign out_count     = out_count_r;
endmodule

// File: tb/tb_req_rsp_elastic_buf.sv
// Scoreboard bench for req_rsp_elastic_buf: directed pushes queue their expected words,
// and a negedge monitor checks popped data plus a reference occupancy/counter model.
module tb_req_rsp_elastic_buf;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 32;
    localparam int PTR_W  = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [PTR_W-1:0]  level;
    logic [CNT_W-1:0]  in_count;
    logic [CNT_W-1:0]  out_count;

    req_rsp_elastic_buf_if #(.DATA_W(DATA_W)) bus ();

    req_rsp_elastic_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .level     (level),
        .in_count  (in_count),
        .out_count (out_count)
    );

    always #5 clock = ~clock;

    int               checks   = 0;
    int               failures = 0;
    logic [31:0]      exp_q[$];
    bit               chk_en   = 1'b0;
    int               m_level  = 0;
    logic [CNT_W-1:0] m_in     = '0;
    logic [CNT_W-1:0] m_out    = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT against the reference model, then advance the model.
    always @(negedge clock) begin
        bit m_push;
        bit m_pop;
        if (chk_en) begin
            check("level", 64'(level), 64'(m_level));
            check("in_ready", 64'(bus.in_ready), 64'(m_level != DEPTH));
            check("out_valid", 64'(bus.out_valid), 64'(m_level != 0));
            check("in_count", 64'(in_count), 64'(m_in));
            check("out_count", 64'(out_count), 64'(m_out));
        end
        m_push = !reset && bus.in_valid && (m_level < DEPTH);
        m_pop  = !reset && bus.out_ready && (m_level > 0);
        if (chk_en && m_pop) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 64'(bus.out_data), 64'hDEAD_0000_0000_0000);
            end else begin
                check("out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
            end
        end
        if (reset) begin
            m_level = 0;
            m_in    = '0;
            m_out   = '0;
            chk_en  = 1'b1;
        end else begin
            m_level = m_level + int'(m_push) - int'(m_pop);
            m_in    = m_in + CNT_W'(m_push);
            m_out   = m_out + CNT_W'(m_pop);
        end
    end

    // Present one word until accepted; the expected copy is queued on issue.
    task automatic push_word(input logic [31:0] d);
        bit acc;
        acc = 1'b0;
        exp_q.push_back(d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clock);
            acc = bus.in_ready;
            @(posedge clock);
            #1;
        end
        if (!acc) check("push_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        repeat (2) @(posedge clock);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        logic [31:0] d;
        int sent;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        void'($urandom(32'd1234));

        // 1: reset for 5 cycles, then idle state
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_counts", {32'(in_count), 32'(out_count)}, 64'd0);
        @(posedge clock);
        #1;

        // 2: fill with out_ready low, 5th word held off
        push_word(32'h11);
        push_word(32'h22);
        push_word(32'h33);
        push_word(32'h44);
        exp_q.push_back(32'h55);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h55;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("full_level", 64'(level), 64'd4);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("full_in_count", 64'(in_count), 64'd4);

        // 3: release back-pressure while holding 0x55
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clock);
            acc = bus.in_ready;
            @(posedge clock);
            #1;
        end
        check("word55_accepted", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
        drain();
        check("t3_counts", {32'(in_count), 32'(out_count)}, {32'd5, 32'd5});

        // 4: streaming, one transfer per cycle
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(32'(i));
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(i);
            @(posedge clock);
            #1;
            if (i == 8) check("stream_level", 64'(level), 64'd1);
        end
        bus.in_valid = 1'b0;
        drain();

        // 5: random valid/ready, 1000 words
        sent = 0;
        for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
            if (!bus.in_valid && ($urandom_range(0, 3) != 0)) begin
                d = $urandom;
                exp_q.push_back(d);
                bus.in_valid = 1'b1;
                bus.in_data  = d;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clock);
            #1;
            if (acc) begin
                bus.in_valid = 1'b0;
                sent++;
            end
        end
        check("random_sent", 64'(sent), 64'd1000);
        bus.in_valid = 1'b0;
        drain();

        // 6: reset with stored data, then a fresh word is first out
        bus.out_ready = 1'b0;
        push_word(32'hC0DE_0001);
        push_word(32'hC0DE_0002);
        push_word(32'hC0DE_0003);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst2_level", 64'(level), 64'd0);
        check("rst2_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clock);
        #1;
        push_word(32'hA5A5_A5A5);
        drain();
        check("rst2_counts", {32'(in_count), 32'(out_count)}, {32'd1, 32'd1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
